// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multi-cycle MIPS-style main control FSM.
// Waits on mem_ready in every memory state; flags illegal opcodes.
module mcycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   is_mem, is_r, is_beq, is_addi, is_j, op_ok;
  logic   pcwrite, branch;

  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_r    = (op == OP_R);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);
  assign op_ok   = is_mem | is_r | is_beq | is_addi | is_j;

  assign state = state_q;

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          is_mem:  state_d = MEMADR;
          is_r:    state_d = RTYPEEX;
          is_beq:  state_d = BEQEX;
          is_addi: state_d = ADDIEX;
          is_j:    state_d = JEX;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Datapath controls; Moore except irwrite, pcen and illegal.
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_ok;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | (branch & zero);
  end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port `op`, input, 6 bits: opcode of the instruction held in the instruction register.
REQ-004 SHALL have port `zero`, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port `mem_ready`, input, 1 bit: memory access completes in the cycle it is 1.
REQ-006 SHALL have port `iord`, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
REQ-007 SHALL have ports `memwrite`, `irwrite`, `regwrite`, output, 1 bit each: write enables.
REQ-008 SHALL have ports `regdst`, `memtoreg`, `alusrca`, output, 1 bit each: datapath mux selects.
REQ-009 SHALL have ports `alusrcb`, `pcsrc`, `aluop`, output, 2 bits each: datapath selects; `aluop` feeds the ALU decoder.
REQ-010 SHALL have port `pcen`, output, 1 bit: PC load enable.
REQ-011 SHALL have port `state`, output, 4 bits: current state code, for debug.
REQ-012 SHALL have port `illegal`, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-013 SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-014 SHALL take the following FETCH transition: mem_ready=1 -> DECODE; otherwise stay in FETCH.
REQ-015 SHALL take the following DECODE transitions, on op: 100011 or 101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH.
REQ-016 SHALL take the following MEMADR transitions: op=100011 -> MEMRD; otherwise -> MEMWR.
REQ-017 SHALL take the following MEMRD and MEMWR transitions: MEMRD -> MEMWB when mem_ready=1, else stay; MEMWR -> FETCH when mem_ready=1, else stay.
REQ-018 SHALL take the following remaining transitions: MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX -> FETCH; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
REQ-019 SHALL drive all outputs as functions of the current state only, except that `irwrite`, `pcen` and `illegal` also depend on inputs; every output not listed for a state SHALL be 0.
REQ-020 SHALL drive, in FETCH: alusrcb=01, irwrite=mem_ready, internal pcwrite=mem_ready.
REQ-021 SHALL drive, in DECODE: alusrcb=11, plus `illegal`=1 when op is not in REQ-015's list.
REQ-022 SHALL drive, in MEMADR and ADDIEX: alusrca=1, alusrcb=10.
REQ-023 SHALL drive, in MEMRD: iord=1.
REQ-024 SHALL drive, in MEMWR: iord=1, memwrite=1, held until mem_ready=1.
REQ-025 SHALL drive, in MEMWB: memtoreg=1, regwrite=1.
REQ-026 SHALL drive, in RTYPEEX: alusrca=1, aluop=10.
REQ-027 SHALL drive, in RTYPEWB: regdst=1, regwrite=1.
REQ-028 SHALL drive, in ADDIWB: regwrite=1.
REQ-029 SHALL drive, in BEQEX: alusrca=1, aluop=01, pcsrc=01, internal branch=1.
REQ-030 SHALL drive, in JEX: pcsrc=10, internal pcwrite=1.
REQ-031 SHALL compute pcen = pcwrite OR (branch AND zero), combinationally within the same cycle.
REQ-032 SHALL have the following instruction latencies, with mem_ready constantly 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-033 SHALL extend each memory state by exactly one cycle per cycle that mem_ready=0, and SHALL NOT pulse regwrite, irwrite or pcen during those wait cycles.

Reset
REQ-034 SHALL force state to FETCH immediately, without waiting for a clock edge, when reset=0.
REQ-035 SHALL hold the FETCH outputs (REQ-020) while reset=0, with `illegal`=0.
REQ-036 SHALL abandon any instruction in progress when reset is asserted mid-instruction, including in MEMWR, and SHALL leave no residual write enables.
REQ-037 SHALL perform its first transition on the first rising edge after reset=1.

Verification
REQ-038 SHALL pass this scenario: lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-039 SHALL pass this scenario: beq with zero=1 in BEQEX -> pcen=1 and pcsrc=01 in state 8; with zero=0 -> pcen=0; both cases return to state 0 after 3 cycles.
REQ-040 SHALL pass this scenario: sw with mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then state 0.
REQ-041 SHALL pass this scenario: op=111111 in DECODE -> illegal=1 for one cycle, next state 0, no regwrite or memwrite.
REQ-042 SHALL pass this scenario: R-type (op=000000) -> aluop=10 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-043 SHALL pass this scenario: reset=0 asserted asynchronously in state 5 -> state=0 and memwrite=0 before the next clock edge.
